mul_sequencer: RTL and testbench

- Multi-cycle radix-2 shift-add multiplier with its own sequencing FSM for the M-extension ops the control unit decodes (mul, mulh, mulhu).
- Sits beside the ALU in execute.
- Accepts a start pulse and operands, holds the pipeline via stall while iterating, then presents the result for one writeback cycle.
- Replaces a single-cycle 32x32 multiplier, to relieve timing on the ALU path.

---
 rtl/mul_sequencer.sv | 139 +++++++++++++
 tb/tb_mul_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier for mul/mulh/mulhu. It stalls execute while it iterates and pulses done for one cycle.
// Build option MUL_EARLY_EXIT_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;
  localparam int         CW       = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]   ONE_X  = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_2X = (2*XLEN)'(1);

  // Handshake: a request is taken in the cycle where start is high, aluop is
  // one of the three multiply ops, and the sequencer is in IDLE or DONE.
  // There is no back-pressure on the result: done is high for exactly one
  // cycle, and result stays valid until the FIX cycle of the next operation.
  state_e                state_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [2*XLEN-1:0]     mcand_q;
  logic [XLEN-1:0]       mplier_q;
  logic [XLEN-1:0]       result_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q;
  logic                  high_q;
  logic                  done_q;
  logic                  busy_q;

  logic                  op_ok;
  logic                  accept;
  logic                  signed_op;
  logic [XLEN-1:0]       a_mag;
  logic [XLEN-1:0]       b_mag;
  logic [2*XLEN-1:0]     acc_sum;
  logic [2*XLEN-1:0]     acc_fix;
  logic                  last_iter;
  logic                  early_exit;

  always_comb begin
    op_ok     = (aluop == OP_MUL) || (aluop == OP_MULH) || (aluop == OP_MULHU);
    accept    = start && op_ok && ((state_q == IDLE) || (state_q == DONE));
    signed_op = (aluop == OP_MULH);
    // Magnitude of the most negative value wraps to itself; read as unsigned, that is the correct magnitude.
    a_mag     = (signed_op && a[XLEN-1]) ? (~a + ONE_X) : a;
    b_mag     = (signed_op && b[XLEN-1]) ? (~b + ONE_X) : b;
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_fix   = neg_q ? (~acc_q + ONE_2X) : acc_q;
    last_iter = (cnt_q == CW'(1));
`ifdef MUL_EARLY_EXIT_EN
    early_exit = (mplier_q == '0);
`else
    early_exit = 1'b0;
`endif
  end

  // stall has to be high in the request cycle itself so that the PC does not advance past the multiply.
  assign stall       = accept || (state_q == BUSY) || (state_q == FIX);
  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      high_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
            cnt_q    <= CW'(XLEN);
            neg_q    <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            high_q   <= (aluop != OP_MUL);
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end else begin
            state_q  <= IDLE;
          end
        end
        BUSY: begin
          if (early_exit) begin
            state_q <= FIX;
          end else begin
            // The multiplicand moves left instead of shifting it by a variable amount each cycle.
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (last_iter) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          acc_q    <= acc_fix;
          result_q <= high_q ? acc_fix[2*XLEN-1:XLEN] : acc_fix[XLEN-1:0];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: directed vectors, sequences for the multi-cycle corner cases, and random operations checked against a 64-bit arithmetic model.
module tb_mul_sequencer;

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;
  localparam int         XLEN     = 32;
  localparam int         BUDGET   = 60;

  logic            clk;
  logic            rst;
  logic            start;
  logic [3:0]      aluop;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;
  logic [1:0]      dbg_state;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] av;
    logic [XLEN-1:0] bv;
    logic [XLEN-1:0] exp_res;
  } vec_t;

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .aluop       (aluop),
    .a           (a),
    .b           (b),
    .result      (result),
    .done        (done),
    .busy        (busy),
    .stall       (stall),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: full-width arithmetic products
  function automatic logic [XLEN-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    longint unsigned up;
    longint          sp;
    up = {32'b0, x} * {32'b0, y};
    sp = longint'($signed(x)) * longint'($signed(y));
    case (op)
      OP_MUL:  return up[31:0];
      OP_MULH: return sp[63:32];
      default: return up[63:32];
    endcase
  endfunction

  // Cycles from accept (T) to the done pulse
  function automatic int exp_lat(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
`ifdef MUL_EARLY_EXIT_EN
    logic [XLEN-1:0] ym;
    int n;
    ym = (op == OP_MULH && y[XLEN-1]) ? (~y + 32'd1) : y;
    n = 0;
    for (int i = 0; i < XLEN; i++) if (ym[i]) n = i + 1;
    return (n + 3 < XLEN + 2) ? n + 3 : XLEN + 2;
`else
    return XLEN + 2;
`endif
  endfunction

  // Driver task: presents a request at the current mid-cycle point and follows it to done.
  // It returns 1 ns after the negedge of the done cycle, so a following call requests in DONE.
  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                        input logic [XLEN-1:0] exp_res, input int inject_at);
    int lat;
    bit ok_ctl;
    bit seen;
    lat    = exp_lat(op, av, bv);
    ok_ctl = 1'b1;
    seen   = 1'b0;
    start  = 1'b1;
    aluop  = op;
    a      = av;
    b      = bv;
    #1;
    check("stall_at_accept", stall, 1);
    for (int k = 1; k <= BUDGET && !seen; k++) begin
      @(negedge clk);
      if (k == inject_at) begin
        start = 1'b1;
        aluop = OP_MULHU;
        a     = '1;
        b     = '1;
      end else begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      #1;
      if (done) begin
        seen = 1'b1;
        check("latency", k, lat);
        check("result", result, exp_res);
        if (stall || busy) ok_ctl = 1'b0;
      end else if (!stall || !busy) begin
        ok_ctl = 1'b0;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("stall_busy_profile", ok_ctl, 1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [1:0]      st0;
    int              n_done;
    logic [3:0]      rop;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    logic [XLEN-1:0] specials[4];

    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    aluop = 4'b0000;
    a     = '0;
    b     = '0;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'h8000_0000;
    specials[3] = 32'hFFFF_FFFF;

    repeat (2) @(negedge clk);
    check("reset_result", result, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{OP_MUL,   32'd7,          32'd6,          32'h0000_002A});
    vecs.push_back('{OP_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000});
    vecs.push_back('{OP_MULH,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000});
    vecs.push_back('{OP_MULH,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF});
    vecs.push_back('{OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE});
    vecs.push_back('{OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001});
    vecs.push_back('{OP_MUL,   32'd5,          32'd0,          32'h0000_0000});
    vecs.push_back('{OP_MUL,   32'd5,          32'd1,          32'h0000_0005});
    vecs.push_back('{OP_MULH,  32'd3,          32'h8000_0000,  32'hFFFF_FFFE});
    vecs.push_back('{OP_MULHU, 32'h8000_0000,  32'd2,          32'h0000_0001});
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].exp_res, 0);
    end

    // The result holds after the done pulse, and done lasts a single cycle.
    run_op(OP_MUL, 32'd7, 32'd6, 32'h2A, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    repeat (9) @(negedge clk);
    #1;
    check("result_hold", result, 32'h2A);

    // A start during BUSY is ignored and the operation in flight completes unchanged.
    run_op(OP_MUL, 32'd7, 32'd6, 32'h2A, 5);

    // A start with a non-multiply aluop must not stall or start anything.
    @(negedge clk);
    st0   = dbg_state;
    start = 1'b1;
    aluop = 4'b0011;
    #1;
    check("bad_op_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("bad_op_busy", busy, 0);
    check("bad_op_state", dbg_state, st0);

    // Reset mid-BUSY clears the outputs at once, and no done pulse follows.
    start = 1'b1;
    aluop = OP_MUL;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_result", result, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_abort", n_done, 0);
    run_op(OP_MUL, 32'd3, 32'd5, 32'd15, 0);

    // Random operations, with some issued back-to-back from DONE.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       rop = OP_MUL;
        1:       rop = OP_MULH;
        default: rop = OP_MULHU;
      endcase
      ra = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op(rop, ra, rb, model(rop, ra, rb), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
